lzs_bit_unpack: RTL and testbench



---
 rtl/lzs_unpack_pkg.sv | 12 +
 rtl/lzs_bit_shifter.sv | 25 ++
 rtl/lzs_bit_unpack.sv | 103 ++++++++++
 tb/tb_lzs_bit_unpack.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzs_unpack_pkg.sv
// Shared constants and helpers for the LZS input bit unpacker.
package lzs_unpack_pkg;

    localparam int BYTE_W  = 8;
    localparam int BYTE_LG = 3;

    // Bits still to discard to reach the next byte boundary of the consumed stream.
    function automatic logic [BYTE_LG-1:0] align_drop(input logic [BYTE_LG-1:0] pos);
        return BYTE_LG'((BYTE_W - int'(pos)) % BYTE_W);
    endfunction

endpackage

// File: rtl/lzs_bit_shifter.sv
// Buffer datapath: drop shamt bits off the top of a left-aligned register and
// optionally insert a fresh source word directly below the surviving bits.
module lzs_bit_shifter #(
    parameter int IN_WIDTH = 64,
    parameter int CW       = 8
) (
    input  logic [2*IN_WIDTH-1:0] bits_in,
    input  logic [CW-1:0]         cnt,
    input  logic [CW-1:0]         shamt,
    input  logic                  ins,
    input  logic [IN_WIDTH-1:0]   ins_dat,
    output logic [2*IN_WIDTH-1:0] bits_out
);

    logic [CW-1:0]         rem;
    logic [2*IN_WIDTH-1:0] ins_word;

    // Bits below cnt are always zero, so OR-ing the insert word is safe.
    always_comb begin
        rem      = cnt - shamt;
        ins_word = ins ? ({ins_dat, {IN_WIDTH{1'b0}}} >> rem) : '0;
        bits_out = (bits_in << shamt) | ins_word;
    end

endmodule

// File: rtl/lzs_bit_unpack.sv
// Pulls source words into a 2-word bit buffer and serves an MSB-first peek
// window; supports variable-width consume, byte align, flush and bit counting.
module lzs_bit_unpack
    import lzs_unpack_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 13,
    parameter int W_BITS    = 4,
    parameter int CNT_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 src_empty,
    input  logic [IN_WIDTH-1:0]  fi,
    output logic                 m_src_getn,
    input  logic [W_BITS-1:0]    stream_width,
    input  logic                 stream_ack,
    output logic [OUT_WIDTH-1:0] stream_data,
    output logic                 stream_valid,
    input  logic                 align_req,
    output logic                 align_done,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] bit_cnt
);

    localparam int BUF_W = 2 * IN_WIDTH;
    localparam int CW    = $clog2(BUF_W + 1);

    logic [BUF_W-1:0]   shreg;
    logic [BUF_W-1:0]   shreg_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [CW-1:0]      shamt;
    logic [CW-1:0]      width_ext;
    logic [CW-1:0]      drop_ext;
    logic [BYTE_LG-1:0] drop;
    logic               pending;
    logic               align_pend;
    logic               run;
    logic               fetch;
    logic               consume;
    logic               align_fire;

    assign width_ext = CW'(stream_width);
    assign drop      = align_drop(bit_cnt[BYTE_LG-1:0]);
    assign drop_ext  = CW'(drop);

    always_comb begin
        run          = ce && !rst && !flush;
        stream_valid = (cnt >= width_ext) && (stream_width != '0) && !align_pend;
        // cnt <= IN_WIDTH guarantees the returning word always fits.
        fetch        = run && !src_empty && !pending && (cnt <= CW'(IN_WIDTH));
        align_fire   = run && align_pend && (cnt >= drop_ext);
        consume      = run && stream_ack && stream_valid;
        shamt        = '0;
        if (align_fire) begin
            shamt = drop_ext;
        end else if (consume) begin
            shamt = width_ext;
        end
        cnt_nxt = cnt - shamt + (pending ? CW'(IN_WIDTH) : '0);
    end

    assign m_src_getn = !fetch;
    assign align_done = align_fire;

    lzs_bit_shifter #(
        .IN_WIDTH (IN_WIDTH),
        .CW       (CW)
    ) u_shifter (
        .bits_in  (shreg),
        .cnt      (cnt),
        .shamt    (shamt),
        .ins      (pending),
        .ins_dat  (fi),
        .bits_out (shreg_nxt)
    );

    // A word in flight is still captured with ce low; a flush drops it.
    always_ff @(posedge clk) begin
        if (rst || (ce && flush)) begin
            shreg       <= '0;
            cnt         <= '0;
            pending     <= 1'b0;
            align_pend  <= 1'b0;
            stream_data <= '0;
            bit_cnt     <= '0;
        end else begin
            shreg       <= shreg_nxt;
            cnt         <= cnt_nxt;
            pending     <= fetch;
            stream_data <= shreg_nxt[BUF_W-1 -: OUT_WIDTH];
            bit_cnt     <= bit_cnt + CNT_WIDTH'(shamt);
            if (align_fire) begin
                align_pend <= 1'b0;
            end else if (ce && align_req) begin
                align_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lzs_bit_unpack.sv
// Bench for lzs_bit_unpack: directed table, corner sequences, then random traffic
// checked against a bit-queue reference model.
module tb_lzs_bit_unpack;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        src_empty;
    logic [63:0] fi;
    logic        m_src_getn;
    logic [3:0]  stream_width;
    logic        stream_ack;
    logic [12:0] stream_data;
    logic        stream_valid;
    logic        align_req;
    logic        align_done;
    logic        flush;
    logic [19:0] bit_cnt;

    lzs_bit_unpack dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .src_empty    (src_empty),
        .fi           (fi),
        .m_src_getn   (m_src_getn),
        .stream_width (stream_width),
        .stream_ack   (stream_ack),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .align_req    (align_req),
        .align_done   (align_done),
        .flush        (flush),
        .bit_cnt      (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Source FIFO contents and the reference model state.
    logic [63:0] q[$];
    bit          mq[$];
    bit          m_pend  = 0;
    bit          m_align = 0;
    logic [63:0] m_word  = '0;
    int unsigned m_bits  = 0;

    typedef struct {
        bit          ce;
        bit          ack;
        bit          areq;
        bit          fl;
        int          w;
        bit          getn;
        logic [12:0] data;
        bit          valid;
        bit          done;
        int          bits;
    } row_t;

    row_t rows[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] w);
        q.push_back(w);
        src_empty = 1'b0;
    endtask

    function automatic logic [12:0] top13();
        logic [12:0] r;
        r = '0;
        for (int i = 0; i < 13; i++) begin
            if (i < mq.size()) r[12-i] = mq[i];
        end
        return r;
    endfunction

    // One clock: check combinational outputs mid-cycle, advance the model,
    // then serve the FIFO and check registered outputs just after the edge.
    task automatic cycle();
        int drop;
        int w;
        bit e_valid;
        bit e_fetch;
        bit e_done;
        bit g;
        @(negedge clk);
        w       = int'(stream_width);
        drop    = (8 - int'(m_bits % 8)) % 8;
        e_valid = (mq.size() >= w) && (w != 0) && !m_align;
        e_fetch = !rst && ce && !flush && !src_empty && !m_pend && (mq.size() <= 64);
        e_done  = !rst && ce && !flush && m_align && (mq.size() >= drop);
        if (!rst) begin
            chk("valid", 32'(stream_valid), 32'(e_valid));
            chk("getn", 32'(m_src_getn), 32'(!e_fetch));
            chk("align_done", 32'(align_done), 32'(e_done));
        end
        g = !m_src_getn;
        if (rst || (ce && flush)) begin
            mq.delete();
            m_pend  = 0;
            m_align = 0;
            m_bits  = 0;
        end else begin
            if (e_done) begin
                for (int i = 0; i < drop; i++) void'(mq.pop_front());
                m_bits += drop;
                m_align = 0;
            end else begin
                if (ce && stream_ack && e_valid) begin
                    for (int i = 0; i < w; i++) void'(mq.pop_front());
                    m_bits += w;
                end
                if (ce && align_req) m_align = 1;
            end
            if (m_pend) begin
                for (int i = 63; i >= 0; i--) mq.push_back(m_word[i]);
            end
            m_pend = e_fetch;
            if (e_fetch) m_word = q[0];
        end
        @(posedge clk);
        #1;
        if (g && q.size() != 0) fi = q.pop_front();
        src_empty = (q.size() == 0);
        cyc++;
        chk("data", 32'(stream_data), 32'(top13()));
        chk("bit_cnt", 32'(bit_cnt), m_bits % (1 << 20));
    endtask

    task automatic set_in(input bit c, input bit a, input bit ar, input bit f, input int w);
        ce           = c;
        stream_ack   = a;
        align_req    = ar;
        flush        = f;
        stream_width = 4'(w);
    endtask

    initial begin
        logic [63:0] w0;
        logic [63:0] w1;
        logic [63:0] w2;
        logic [63:0] w3;
        logic [63:0] w4;
        int          k;

        //          ce ack areq fl  w | getn data     valid done bits
        rows[0]  = '{1, 0, 0, 0, 13,   0, 13'h0000, 0, 0, 0};
        rows[1]  = '{1, 0, 0, 0, 13,   1, 13'h0000, 0, 0, 0};
        rows[2]  = '{1, 1, 0, 0, 3,    1, 13'h14B4, 1, 0, 0};
        rows[3]  = '{1, 0, 1, 0, 3,    1, 13'h05A5, 1, 0, 3};
        rows[4]  = '{1, 0, 0, 0, 13,   1, 13'h05A5, 0, 1, 3};
        rows[5]  = '{1, 0, 0, 0, 13,   1, 13'h14A0, 1, 0, 8};
        rows[6]  = '{0, 1, 0, 0, 13,   1, 13'h14A0, 1, 0, 8};
        rows[7]  = '{0, 1, 0, 0, 13,   1, 13'h14A0, 1, 0, 8};
        rows[8]  = '{1, 1, 0, 0, 13,   1, 13'h14A0, 1, 0, 8};
        rows[9]  = '{1, 0, 0, 1, 13,   1, 13'h0000, 1, 0, 21};
        rows[10] = '{1, 0, 0, 0, 13,   1, 13'h0000, 0, 0, 0};

        w0 = 64'hA5A5_0000_0000_0001;
        rst = 1'b1;
        fi = '0;
        src_empty = 1'b1;
        set_in(1, 0, 0, 0, 13);
        push(w0);
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_data", 32'(stream_data), 32'h0);
        chk("reset_bit_cnt", 32'(bit_cnt), 32'h0);

        for (int r = 0; r < 11; r++) begin
            set_in(rows[r].ce, rows[r].ack, rows[r].areq, rows[r].fl, rows[r].w);
            #3;
            chk($sformatf("row%0d_getn", r), 32'(m_src_getn), 32'(rows[r].getn));
            chk($sformatf("row%0d_data", r), 32'(stream_data), 32'(rows[r].data));
            chk($sformatf("row%0d_valid", r), 32'(stream_valid), 32'(rows[r].valid));
            chk($sformatf("row%0d_done", r), 32'(align_done), 32'(rows[r].done));
            chk($sformatf("row%0d_bits", r), 32'(bit_cnt), 32'(rows[r].bits));
            cycle();
        end

        // Starve with 7 bits left and a 9-bit request, then refill.
        w1 = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        push(w1);
        set_in(1, 0, 0, 0, 13);
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 0, 0, 13);
            cycle();
        end
        set_in(1, 1, 0, 0, 5);
        cycle();
        set_in(1, 1, 0, 0, 9);
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("starve_valid", 32'(stream_valid), 32'h0);
            cycle();
        end
        chk("starve_bits", 32'(bit_cnt), 32'd57);
        set_in(1, 0, 0, 0, 9);
        push(w2);
        cycle();
        cycle();
        #3;
        chk("refill_data", 32'(stream_data), 32'({w1[6:0], w2[63:58]}));
        chk("refill_valid", 32'(stream_valid), 32'h1);

        // Four words consumed 13 bits at a time.
        set_in(1, 0, 0, 1, 13);
        cycle();
        for (int i = 0; i < 4; i++) push({$urandom, $urandom});
        set_in(1, 1, 0, 0, 13);
        k = 0;
        for (int i = 0; i < 30; i++) begin
            #3;
            if (stream_valid) k++;
            cycle();
        end
        chk("b2b_count", 32'(k), 32'd19);
        chk("b2b_bits", 32'(bit_cnt), 32'd247);

        // Flush while a get is in flight.
        set_in(1, 0, 0, 1, 13);
        cycle();
        w3 = {$urandom, $urandom};
        w4 = {$urandom, $urandom};
        push(w3);
        push(w4);
        set_in(1, 0, 0, 0, 13);
        #3;
        chk("pend_getn", 32'(m_src_getn), 32'h0);
        cycle();
        set_in(1, 0, 0, 1, 13);
        cycle();
        set_in(1, 0, 0, 0, 13);
        cycle();
        cycle();
        #3;
        chk("pend_flush_data", 32'(stream_data), 32'(w4[63:51]));
        chk("pend_flush_bits", 32'(bit_cnt), 32'h0);
        chk("pend_flush_valid", 32'(stream_valid), 32'h1);

        // ce low for 5 cycles with ack held.
        set_in(1, 1, 0, 0, 13);
        cycle();
        set_in(0, 1, 0, 0, 13);
        for (int i = 0; i < 5; i++) cycle();
        chk("ce_hold_bits", 32'(bit_cnt), 32'd13);
        chk("ce_hold_data", 32'(stream_data), 32'(w4[50:38]));
        set_in(1, 1, 0, 0, 13);
        cycle();

        // Random traffic, alternating well-fed and starved phases.
        for (int n = 0; n < 3000; n++) begin
            if (q.size() < 2 && ((n / 300) % 2 == 0 || $urandom_range(0, 7) == 0))
                push({$urandom, $urandom});
            set_in($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                   $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0,
                   $urandom_range(0, 13));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
